// File: rtl/adder_axil_driver.sv
// AXI4-Lite master sequencer for the adder0 slave: writes operand A and B,
// reads back the result register and returns the sum with an error flag.
module adder_axil_driver #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [3:0]  OPA_OFFSET = 4'h0,
    parameter logic [3:0]  OPB_OFFSET = 4'h4,
    parameter logic [3:0]  RES_OFFSET = 4'h8
) (
    input  logic        ACLK,
    input  logic        ARESET,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,

    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,

    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,

    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,

    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,

    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,

    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam logic [ADDR_W-1:0] OPA_ADDR = BASE_ADDR + ADDR_W'(OPA_OFFSET);
    localparam logic [ADDR_W-1:0] OPB_ADDR = BASE_ADDR + ADDR_W'(OPB_OFFSET);
    localparam logic [ADDR_W-1:0] RES_ADDR = BASE_ADDR + ADDR_W'(RES_OFFSET);

    typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_AR, RD_R, OUT} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                err_q, err_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

    logic                cmd_ready_d, res_valid_d, res_err_d;
    logic [DATA_W-1:0]   res_data_d, wdata_d;
    logic [ADDR_W-1:0]   awaddr_d, araddr_d;
    logic                awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic unused_resp;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = m_axi_bready & m_axi_bvalid;
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rready & m_axi_rvalid;

    // Only bit[1] of a response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    assign unused_resp = ^{m_axi_bresp[0], m_axi_rresp[0]};

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;

    // State and registered outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= IDLE;
            b_q           <= '0;
            err_q         <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            cmd_ready     <= 1'b0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_err       <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            state_q       <= state_d;
            b_q           <= b_d;
            err_q         <= err_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            cmd_ready     <= cmd_ready_d;
            res_valid     <= res_valid_d;
            res_data      <= res_data_d;
            res_err       <= res_err_d;
            m_axi_awaddr  <= awaddr_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wdata   <= wdata_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_araddr  <= araddr_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        err_d       = err_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        cmd_ready_d = 1'b0;
        res_valid_d = res_valid;
        res_data_d  = res_data;
        res_err_d   = res_err;
        awaddr_d    = m_axi_awaddr;
        awvalid_d   = 1'b0;
        wdata_d     = m_axi_wdata;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        araddr_d    = m_axi_araddr;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_d = 1'b0;
                    b_d         = cmd_b;
                    err_d       = 1'b0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    awaddr_d    = OPA_ADDR;
                    wdata_d     = cmd_a;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    state_d     = WR_A;
                end
            end
            WR_A, WR_B: begin
                // AW and W retire independently; B is only accepted after both.
                awvalid_d = m_axi_awvalid & ~m_axi_awready;
                wvalid_d  = m_axi_wvalid & ~m_axi_wready;
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                bready_d  = aw_done_d & w_done_d & ~b_hs;
                if (b_hs) begin
                    err_d = err_q | m_axi_bresp[1];
                    if (state_q == WR_A) begin
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        awaddr_d  = OPB_ADDR;
                        wdata_d   = b_q;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_B;
                    end else begin
                        araddr_d  = RES_ADDR;
                        arvalid_d = 1'b1;
                        state_d   = RD_AR;
                    end
                end
            end
            RD_AR: begin
                arvalid_d = m_axi_arvalid & ~m_axi_arready;
                if (ar_hs) begin
                    rready_d = 1'b1;
                    state_d  = RD_R;
                end
            end
            RD_R: begin
                rready_d = ~r_hs;
                if (r_hs) begin
                    err_d       = err_q | m_axi_rresp[1];
                    res_data_d  = m_axi_rdata;
                    res_err_d   = err_q | m_axi_rresp[1];
                    res_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/adder_axil_driver.md
# adder_axil_driver

AXI4-Lite master sequencer sitting directly upstream of the adder0 AXI4-Lite slave peripheral. It accepts an operand pair on a valid/ready command port and writes operand A and operand B into the peripheral's registers. It then reads back the result register and presents the sum, plus an error flag, on a valid/ready result port. It lets fabric logic use the adder without a processor or VIP master.

## Interface
- `BASE_ADDR`, 32'h0000_0000: base address of the adder0 slave.
- `OPA_OFFSET`, 4'h0: byte offset of the operand A register.
- `OPB_OFFSET`, 4'h4: byte offset of the operand B register.
- `RES_OFFSET`, 4'h8: byte offset of the result register.
- Address and data width are fixed at 32 bits; `WSTRB` is always 4'hF; `AWPROT`/`ARPROT` are always 3'b000.

Ports:
- `ACLK` in 1: the single clock; all logic is rising-edge.
- `ARESET` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_a` in 32, `cmd_b` in 32: operands, captured on the command handshake.
- `res_valid` out 1 / `res_ready` in 1: result handshake.
- `res_data` out 32: value read from the result register.
- `res_err` out 1: 1 if any BRESP or RRESP of this command had bit[1] set (SLVERR/DECERR).
- `m_axi_awaddr` out 32, `m_axi_awprot` out 3, `m_axi_awvalid` out 1, `m_axi_awready` in 1.
- `m_axi_wdata` out 32, `m_axi_wstrb` out 4, `m_axi_wvalid` out 1, `m_axi_wready` in 1.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1.
- `m_axi_araddr` out 32, `m_axi_arprot` out 3, `m_axi_arvalid` out 1, `m_axi_arready` in 1.
- `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1.

## Operation
- States: IDLE, WR_A, WR_B, RD_AR, RD_R, OUT.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid&cmd_ready`: latch A and B, clear the error accumulator, go to WR_A.
- WR_A / WR_B:
  - Entry: assert AWVALID (addr = BASE_ADDR+offset) and WVALID (data = A or B) in the same cycle.
  - Each VALID drops the cycle after its own handshake; AW and W complete independently, in either order or together.
  - Once both have completed, assert BREADY.
  - On the B handshake: OR `bresp[1]` into the error accumulator. Then WR_A→WR_B, WR_B→RD_AR.
- RD_AR:
  - ARVALID=1 with addr = BASE_ADDR+RES_OFFSET.
  - On the AR handshake, go to RD_R.
- RD_R:
  - RREADY=1.
  - On the R handshake: capture `rdata`, OR `rresp[1]` into the error accumulator, go to OUT.
- OUT:
  - `res_valid`=1, with `res_data`/`res_err` held stable.
  - On `res_ready`, return to IDLE.
- AXI rules:
  - No VALID ever depends combinationally on its READY.
  - Address and data are stable while VALID is high and not yet accepted.
  - Exactly one outstanding transaction at a time.
- A B or R response arriving while not expected is ignored, because BREADY and RREADY are 0 outside their states.
- Arithmetic is performed entirely by the slave. The block never modifies data, including 32-bit wrap (FFFF_FFFF+1 returns whatever the slave returns).

## Timing
- Reset (asynchronous, immediate): state IDLE; `cmd_ready`=0 while ARESET is high, 1 after release; all VALID/READY outputs 0; `res_data`=0; `res_err`=0; addresses and wdata 0.
- Reset mid-transaction: the outputs drop immediately and nothing completes. A response from the slave after release is ignored. The command is lost and the system resets the slave together with this block.
- Command handshake at cycle 0 → AWVALID/WVALID rise in cycle 1.
- With a slave that sets READY in the VALID cycle and responds in the next cycle:
  - AW/W accepted in cycle 1, B accepted in cycle 2.
  - Second write in cycles 3–4.
  - AR in cycle 5, R in cycle 6.
  - `res_valid` in cycle 7.
- Slave wait states add 1:1 to this latency.
- `cmd_ready` is 0 from cycle 1 until the cycle after the result handshake, so the command-to-command minimum is 8 cycles.

## Test plan
- Basic add: A=3, B=5 with a zero-wait slave → AW addresses 0x0 then 0x4 with data 3 then 5, AR addr 0x8, `res_data`=8 and `res_err`=0 in cycle 7.
- Skewed acceptance: slave asserts WREADY 3 cycles before AWREADY on the first write → WVALID drops after its handshake, AWVALID is held with a stable address, BREADY rises only after both handshakes, result is correct.
- Result backpressure: `res_ready`=0 for 10 cycles → `res_valid`, `res_data` and `res_err` are stable, `cmd_ready`=0, no AXI VALID is asserted.
- Error: slave returns BRESP=2'b10 on the operand B write → the read still happens and `res_err`=1. The next command with an OKAY response gives `res_err`=0.
- Back-to-back: commands (1,2) then (0xFFFF_FFFF,1) → results 3 then 0, in order, with no overlapping transactions.
- Reset mid-operation: assert ARESET while AWVALID=1 on the operand B write → all VALIDs are 0 in the same cycle; after release, state is IDLE, `cmd_ready`=1 and `res_valid`=0.
